nor_logic_unit: RTL and testbench

- Parametrised, registered bitwise logic unit. Every operator is built only from 2-input NOR primitive instances; no other gate primitives and no behavioural logic operators in the datapath.
- Successor to the single-bit NOR-only implication cell. Adds WIDTH-bit operands, an 8-function operator select, valid/ready streaming and an optional exhaustive truth-table sweep engine.
- Sits between the lab stimulus sequencer and the result checker.

---
 rtl/nor_logic_unit.sv | 192 +++++++++++++++++++
 tb/tb_nor_logic_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_logic_unit.sv
// nor_logic_unit: registered WIDTH-bit logic unit; every function is a 2-input NOR netlist.
// Define NOR_SWEEP_EN to add the exhaustive truth-table sweep engine (start/busy/done/count).
module nor_logic_unit #(
  parameter int WIDTH = 4,
  parameter int CW    = 2*WIDTH + $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef NOR_SWEEP_EN
  ,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
`endif
);

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] sum;
    sum = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      sum = sum + {{(CW-1){1'b0}}, v[i]};
    end
    return sum;
  endfunction

  logic [WIDTH-1:0] net_a_s;
  logic [WIDTH-1:0] net_b_s;
  logic [2:0]       net_op_s;
  logic [WIDTH-1:0] net_y_s;
  logic             busy_s;
  logic             in_fire_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  // Per bit: eight functions from NORs, then a 3-level 2:1 mux tree (also NORs) picks one by op.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic       not_a, not_b, nor_ab, or_ab, and_ab, nand_ab, xor_ab, xnor_ab, a_and_nb, imply_ab;
    logic       s0_n, s1_n, s2_n;
    logic [7:0] fn;
    logic [3:0] lvl0;
    logic [1:0] lvl1;
    logic       hi_n, lo_n, hi_sel, lo_sel, y_n;

    nor g_not_a (not_a,    net_a_s[i], net_a_s[i]);
    nor g_not_b (not_b,    net_b_s[i], net_b_s[i]);
    nor g_nor   (nor_ab,   net_a_s[i], net_b_s[i]);
    nor g_or    (or_ab,    nor_ab,     nor_ab);
    nor g_and   (and_ab,   not_a,      not_b);
    nor g_nand  (nand_ab,  and_ab,     and_ab);
    nor g_xor   (xor_ab,   nor_ab,     and_ab);
    nor g_xnor  (xnor_ab,  xor_ab,     xor_ab);
    nor g_anb   (a_and_nb, not_a,      net_b_s[i]);
    nor g_imply (imply_ab, a_and_nb,   a_and_nb);
    assign fn = {imply_ab, xnor_ab, xor_ab, nand_ab, and_ab, nor_ab, or_ab, not_a};

    nor g_s0 (s0_n, net_op_s[0], net_op_s[0]);
    nor g_s1 (s1_n, net_op_s[1], net_op_s[1]);
    nor g_s2 (s2_n, net_op_s[2], net_op_s[2]);

    for (genvar k = 0; k < 4; k++) begin : g_l0
      logic h_n, l_n, h_sel, l_sel, m_n;
      nor g0 (h_n,     fn[2*k+1], fn[2*k+1]);
      nor g1 (l_n,     fn[2*k],   fn[2*k]);
      nor g2 (h_sel,   s0_n,      h_n);
      nor g3 (l_sel,   net_op_s[0], l_n);
      nor g4 (m_n,     h_sel,     l_sel);
      nor g5 (lvl0[k], m_n,       m_n);
    end

    for (genvar k = 0; k < 2; k++) begin : g_l1
      logic h_n, l_n, h_sel, l_sel, m_n;
      nor g0 (h_n,     lvl0[2*k+1], lvl0[2*k+1]);
      nor g1 (l_n,     lvl0[2*k],   lvl0[2*k]);
      nor g2 (h_sel,   s1_n,        h_n);
      nor g3 (l_sel,   net_op_s[1], l_n);
      nor g4 (m_n,     h_sel,       l_sel);
      nor g5 (lvl1[k], m_n,         m_n);
    end

    nor g_r0 (hi_n,       lvl1[1],     lvl1[1]);
    nor g_r1 (lo_n,       lvl1[0],     lvl1[0]);
    nor g_r2 (hi_sel,     s2_n,        hi_n);
    nor g_r3 (lo_sel,     net_op_s[2], lo_n);
    nor g_r4 (y_n,        hi_sel,      lo_sel);
    nor g_r5 (net_y_s[i], y_n,         y_n);
  end

`ifdef NOR_SWEEP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;

  sweep_state_t     state_r;
  logic [WIDTH-1:0] a_cnt_r;
  logic [WIDTH-1:0] b_cnt_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;

  // While sweeping the shared NOR network is fed from the pair counters instead of the ports.
  assign busy_s   = busy_r;
  assign net_a_s  = busy_r ? a_cnt_r : a;
  assign net_b_s  = busy_r ? b_cnt_r : b;
  assign net_op_s = busy_r ? op_r    : op;
  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;

  // Sweep FSM: b_cnt inner, a_cnt outer; one pair accumulated per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      a_cnt_r <= {WIDTH{1'b0}};
      b_cnt_r <= {WIDTH{1'b0}};
      op_r    <= 3'b000;
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !out_valid_r) begin
            state_r <= ST_SWEEP;
            op_r    <= op;
            count_r <= {CW{1'b0}};
            a_cnt_r <= {WIDTH{1'b0}};
            b_cnt_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          count_r <= count_r + popcount(net_y_s);
          b_cnt_r <= b_cnt_r + WIDTH'(1);
          if (&b_cnt_r) begin
            a_cnt_r <= a_cnt_r + WIDTH'(1);
          end
          if ((&a_cnt_r) && (&b_cnt_r)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign busy_s   = 1'b0;
  assign net_a_s  = a;
  assign net_b_s  = b;
  assign net_op_s = op;
`endif

  assign in_ready  = !reset && !busy_s && (!out_valid_r || out_ready);
  assign in_fire_s = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Output register: load on transfer, hold while stalled, clear after handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else if (in_fire_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= net_y_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nor_logic_unit.sv
// Self-checking bench for nor_logic_unit: behavioural model + directed vectors.
// Sweep scenarios are built only when NOR_SWEEP_EN is defined.
module tb_nor_logic_unit;
  localparam int W  = 4;
  localparam int CW = 2*W + $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef NOR_SWEEP_EN
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp8 [8] = '{4'b0101, 4'b1110, 4'b0001, 4'b0010,
                           4'b1101, 4'b1100, 4'b0011, 4'b0111};

  nor_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef NOR_SWEEP_EN
    ,
    .start     (start),
    .busy      (busy),
    .done      (done),
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] f_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x | y;
      3'd2:    return ~(x | y);
      3'd3:    return x & y;
      3'd4:    return ~(x & y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      default: return ~x | y;
    endcase
  endfunction

  function automatic int sweep_total(input logic [2:0] o);
    int t = 0;
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        t += $countones(f_model(o, W'(i), W'(j)));
      end
    end
    return t;
  endfunction

  // Model: queue of pending results plus a sweep cycle budget; checked every negedge.
  initial begin : p_model
    logic [W-1:0] q[$];
    int  sweep_left;
    int  m_count;
    bit  done_pend, exp_busy, exp_ready, was_empty, fire_in, fire_out;
    sweep_left = 0;
    m_count    = 0;
    done_pend  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        sweep_left = 0;
        m_count    = 0;
        done_pend  = 1'b0;
        check("m_rst_in_ready", 32'(in_ready), 32'(0));
        check("m_rst_out_valid", 32'(out_valid), 32'(0));
        check("m_rst_out_data", 32'(out_data), 32'(0));
`ifdef NOR_SWEEP_EN
        check("m_rst_busy", 32'(busy), 32'(0));
        check("m_rst_done", 32'(done), 32'(0));
        check("m_rst_count", 32'(count), 32'(0));
`endif
      end else begin
        exp_busy  = (sweep_left > 0);
        was_empty = (q.size() == 0);
        exp_ready = !exp_busy && (was_empty || out_ready);
        check("m_in_ready", 32'(in_ready), 32'(exp_ready));
        check("m_out_valid", 32'(out_valid), 32'(!was_empty));
        if (!was_empty) check("m_out_data", 32'(out_data), 32'(q[0]));
`ifdef NOR_SWEEP_EN
        check("m_busy", 32'(busy), 32'(exp_busy));
        check("m_done", 32'(done), 32'(done_pend));
        if (!exp_busy) check("m_count", 32'(count), 32'(m_count));
`endif
        fire_out = !was_empty && out_ready;
        fire_in  = in_valid && exp_ready;
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back(f_model(op, a, b));
`ifdef NOR_SWEEP_EN
        if (done_pend) begin
          done_pend = 1'b0;
        end else if (sweep_left > 0) begin
          sweep_left--;
          if (sweep_left == 0) done_pend = 1'b1;
        end else if (start && was_empty) begin
          sweep_left = 1 << (2*W);
          m_count    = sweep_total(op);
        end
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef NOR_SWEEP_EN
  task automatic run_sweep(input logic [2:0] o, input int exp_cnt, input string nm, input bit poke);
    int busy_cycles = 0;
    bit seen = 1'b0;
    op = o;
    start = 1'b1;
    tick;
    start = 1'b0;
    op = 3'd0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        check({nm, "_count"}, 32'(count), 32'(exp_cnt));
      end
      start = poke && (i == 10);
      if (poke && i == 10) op = 3'd7;
      tick;
    end
    start = 1'b0;
    check({nm, "_timeout"}, 32'(seen), 32'(1));
    check({nm, "_busy_cycles"}, 32'(busy_cycles), 32'(256));
    check({nm, "_done_single"}, 32'(done), 32'(0));
  endtask
`endif

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_drive
    repeat (2) tick;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    reset = 1'b0;
    tick;
    check("in_ready_after_rst", 32'(in_ready), 32'(1));
    check("model_pin_imply", 32'(f_model(3'd7, 4'b1010, 4'b0110)), 32'(4'b0111));
    check("model_pin_xor", 32'(f_model(3'd5, 4'hF, 4'h3)), 32'(4'hC));

    // All eight functions, back to back.
    out_ready = 1'b1;
    a = 4'b1010;
    b = 4'b0110;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op = 3'(k);
      tick;
      check($sformatf("op%0d_data", k), 32'(out_data), 32'(exp8[k]));
      check($sformatf("op%0d_valid", k), 32'(out_valid), 32'(1));
    end
    in_valid = 1'b0;
    tick;
    check("drain_valid", 32'(out_valid), 32'(0));

    // Stall for three cycles, then accept and replace with no bubble.
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd1; a = 4'h5; b = 4'h3;
    tick;
    op = 3'd2;
    for (int k = 0; k < 3; k++) begin
      check("stall_data", 32'(out_data), 32'(4'h7));
      check("stall_in_ready", 32'(in_ready), 32'(0));
      tick;
    end
    out_ready = 1'b1;
    op = 3'd5; a = 4'hF; b = 4'h3;
    tick;
    check("nobubble_data", 32'(out_data), 32'(4'hC));
    check("nobubble_valid", 32'(out_valid), 32'(1));
    in_valid = 1'b0;
    tick;
    check("post_handshake_valid", 32'(out_valid), 32'(0));

    // Asynchronous reset mid-stream.
    in_valid = 1'b1;
    op = 3'd3; a = 4'hC; b = 4'hA;
    tick;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'(0));
    check("async_rst_data", 32'(out_data), 32'(0));
    check("async_rst_in_ready", 32'(in_ready), 32'(0));
    tick;
    reset = 1'b0;
    in_valid = 1'b0;
    tick;
    check("rerelease_in_ready", 32'(in_ready), 32'(1));

`ifdef NOR_SWEEP_EN
    run_sweep(3'd7, 768, "sweep_imply", 1'b0);
    run_sweep(3'd5, 512, "sweep_xor", 1'b0);
    run_sweep(3'd3, 256, "sweep_and_poked", 1'b1);

    // Start with a pending output is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd0; a = 4'h6;
    tick;
    in_valid = 1'b0;
    start = 1'b1;
    op = 3'd7;
    tick;
    start = 1'b0;
    check("start_pending_busy", 32'(busy), 32'(0));
    check("start_pending_count", 32'(count), 32'(256));
    out_ready = 1'b1;
    repeat (2) tick;
    check("start_pending_busy2", 32'(busy), 32'(0));

    // Reset around pair 100 aborts with no done pulse.
    op = 3'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (100) tick;
    check("mid_sweep_busy", 32'(busy), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_count", 32'(count), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    tick;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("abort_no_done", 32'(done), 32'(0));
    end
`endif

    repeat (2) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
